// File: rtl/serial_subtract_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtract_ctrl
// Purpose  : Bit-serial unsigned subtractor, diff = a - b, one bit per clock.
//            Each bit goes through a 1-bit subtract cell made of two cascaded
//            half-subtractor stages, with the borrow carried between bits in
//            a register. Operands arrive and results leave over valid/ready
//            handshakes.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous, active-high reset
//            in_valid   - operand pair a/b valid
//            in_ready   - operands accepted (IDLE only)
//            a, b       - minuend / subtrahend, unsigned, WIDTH bits
//            out_valid  - diff/borrow_out valid (DONE only)
//            out_ready  - consumer accepts the result
//            diff       - (a - b) mod 2^WIDTH
//            borrow_out - 1 when a < b
//            busy       - operation in flight (RUN or DONE)
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_sa;       // minuend shift register, LSB consumed first
  logic [WIDTH-1:0] r_sb;       // subtrahend shift register
  logic [WIDTH-1:0] r_acc;      // result assembly, new bits enter at MSB
  logic [WIDTH-1:0] r_diff;     // published result, only updated on completion
  logic             r_bw;       // borrow chained between bit positions
  logic             r_borrow;   // published final borrow
  logic [CNT_W-1:0] r_cnt;      // bits processed so far in this operation

  logic             w_x;
  logic             w_y;
  logic             w_d1;
  logic             w_b1;
  logic             w_d;
  logic             w_b2;
  logic             w_bw_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;

  // 1-bit subtract cell: first half-subtractor handles x - y, the second
  // folds in the borrow from the previous bit position.
  assign w_x       = r_sa[0];
  assign w_y       = r_sb[0];
  assign w_d1      = w_x ^ w_y;
  assign w_b1      = ~w_x & w_y;
  assign w_d       = w_d1 ^ r_bw;
  assign w_b2      = ~w_d1 & r_bw;
  assign w_bw_nxt  = w_b1 | w_b2;
  assign w_last    = (r_cnt == c_LAST);
  assign w_acc_nxt = {w_d, r_acc[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_bw     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sa  <= a;
            r_sb  <= b;
            r_bw  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_acc <= w_acc_nxt;
          r_bw  <= w_bw_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Publish only on the final bit so diff/borrow_out stay frozen
          // between operations instead of showing the partial shift.
          if (w_last) begin
            r_diff   <= w_acc_nxt;
            r_borrow <= w_bw_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtract_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtract_ctrl
// Purpose  : Self-checking bench for serial_subtract_ctrl at WIDTH=8 and
//            WIDTH=32, directed scenarios plus randomized operands and stalls
//            checked against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtract_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic        out_rdy;
  logic        sel32;
  logic [31:0] a;
  logic [31:0] b;

  logic        ir8, ov8, bo8, busy8;
  logic [7:0]  d8;
  logic        ir32, ov32, bo32, busy32;
  logic [31:0] d32;

  logic        s_ir, s_ov, s_bo, s_busy;
  logic [31:0] s_diff;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtract_ctrl #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv & ~sel32),
    .in_ready   (ir8),
    .a          (a[7:0]),
    .b          (b[7:0]),
    .out_valid  (ov8),
    .out_ready  (out_rdy),
    .diff       (d8),
    .borrow_out (bo8),
    .busy       (busy8)
  );

  serial_subtract_ctrl #(.WIDTH(32)) u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv & sel32),
    .in_ready   (ir32),
    .a          (a),
    .b          (b),
    .out_valid  (ov32),
    .out_ready  (out_rdy),
    .diff       (d32),
    .borrow_out (bo32),
    .busy       (busy32)
  );

  assign s_ir   = sel32 ? ir32   : ir8;
  assign s_ov   = sel32 ? ov32   : ov8;
  assign s_bo   = sel32 ? bo32   : bo8;
  assign s_busy = sel32 ? busy32 : busy8;
  assign s_diff = sel32 ? d32    : {24'd0, d8};

  task automatic tick;
    @(negedge clk);
  endtask

  // Drives one operation with out_ready held high. lat counts sampled cycles
  // from the cycle in which the input handshake is seen to the first cycle
  // with out_valid high. Returns at the cycle after the result transfer.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                       output logic [31:0] od, output logic obo,
                       output int lat, output bit tout);
    tout = 1'b0; od = '0; obo = 1'b0; lat = 0;
    a = oa; b = ob; iv = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 100 && !s_ir; i++) tick();
    if (!s_ir) begin
      tout = 1'b1; iv = 1'b0;
      return;
    end
    tick();
    iv  = 1'b0;
    lat = 1;
    while (!s_ov && lat < 100) begin
      tick();
      lat++;
    end
    if (!s_ov) begin
      tout = 1'b1;
      return;
    end
    od  = s_diff;
    obo = s_bo;
    tick();
  endtask

  task automatic test_reset;
    sel32 = 1'b0; iv = 1'b0; out_rdy = 1'b0; a = '0; b = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({ir8, ov8, busy8, bo8, d8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset8 got ir/ov/busy/bo/diff=%b%b%b%b/%h want 1000/00",
               ir8, ov8, busy8, bo8, d8);
    end
    checks++;
    if ({ir32, ov32, busy32, bo32, d32} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset32 got ir/ov/busy/bo/diff=%b%b%b%b/%h want 1000/0",
               ir32, ov32, busy32, bo32, d32);
    end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    logic bo;
    int lat;
    bit tout;
    sel32 = 1'b0;
    do_op(32'h5A, 32'h3C, d, bo, lat, tout);
    checks++;
    if (tout !== 1'b0) begin
      errors++; $display("FAIL basic_timeout got %0b want 0", tout);
    end
    checks++;
    if ({bo, d[7:0]} !== {1'b0, 8'h1E}) begin
      errors++; $display("FAIL basic_5A_3C got %b/%h want 0/1e", bo, d[7:0]);
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL basic_latency got %0d want 9", lat);
    end
    checks++;
    if ({s_ir, s_ov, s_busy} !== 3'b100) begin
      errors++; $display("FAIL basic_return_idle got ir/ov/busy=%b%b%b want 100",
                         s_ir, s_ov, s_busy);
    end
    do_op(32'h00, 32'h01, d, bo, lat, tout);
    checks++;
    if ({tout, bo, d[7:0]} !== {1'b0, 1'b1, 8'hFF}) begin
      errors++; $display("FAIL zero_minus_one got to/bo/diff=%b/%b/%h want 0/1/ff",
                         tout, bo, d[7:0]);
    end
    do_op(32'hA5, 32'hA5, d, bo, lat, tout);
    checks++;
    if ({tout, bo, d[7:0]} !== {1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL equal_operands got to/bo/diff=%b/%b/%h want 0/0/00",
                         tout, bo, d[7:0]);
    end
  endtask

  task automatic test_backpressure;
    int n;
    sel32 = 1'b0;
    a = 32'h10; b = 32'h20; iv = 1'b1; out_rdy = 1'b0;
    for (int i = 0; i < 100 && !s_ir; i++) tick();
    tick();
    // Keep offering a different pair; it must be ignored while busy.
    a = 32'h77; b = 32'h11;
    n = 0;
    while (!s_ov && n < 100) begin
      tick(); n++;
    end
    checks++;
    if (s_ov !== 1'b1) begin
      errors++; $display("FAIL bp_out_valid got %b want 1", s_ov);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({s_ov, s_bo, s_ir, s_diff[7:0]} !== {1'b1, 1'b1, 1'b0, 8'hF0}) begin
        errors++;
        $display("FAIL bp_stall%0d got ov/bo/ir/diff=%b%b%b/%h want 110/f0",
                 k, s_ov, s_bo, s_ir, s_diff[7:0]);
      end
      tick();
    end
    iv = 1'b0; out_rdy = 1'b1;
    checks++;
    if (s_ov !== 1'b1) begin
      errors++; $display("FAIL bp_before_transfer got ov=%b want 1", s_ov);
    end
    tick();
    checks++;
    if ({s_ov, s_ir, s_busy} !== 3'b010) begin
      errors++; $display("FAIL bp_after_transfer got ov/ir/busy=%b%b%b want 010",
                         s_ov, s_ir, s_busy);
    end
    tick();
    checks++;
    if (s_ov !== 1'b0) begin
      errors++; $display("FAIL bp_single_transfer got ov=%b want 0", s_ov);
    end
  endtask

  task automatic test_reset_abort;
    bit seen;
    sel32 = 1'b0;
    a = 32'hFF; b = 32'h01; iv = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 100 && !s_ir; i++) tick();
    tick();
    iv = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (s_busy !== 1'b1) begin
      errors++; $display("FAIL abort_in_run got busy=%b want 1", s_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({s_ir, s_busy, s_ov, s_bo, s_diff[7:0]} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL abort_state got ir/busy/ov/bo/diff=%b%b%b%b/%h want 1000/00",
               s_ir, s_busy, s_ov, s_bo, s_diff[7:0]);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (s_ov) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_result got out_valid_seen=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  pa [3] = '{8'd3, 8'd1, 8'd200};
    logic [7:0]  pb [3] = '{8'd1, 8'd3, 8'd55};
    logic [8:0]  exp_res [3] = '{{1'b0, 8'h02}, {1'b1, 8'hFE}, {1'b0, 8'h91}};
    logic [8:0]  res [$];
    int          acc [$];
    int          idx;
    bit          load;
    sel32 = 1'b0; out_rdy = 1'b1;
    idx = 0;
    a = {24'd0, pa[0]}; b = {24'd0, pb[0]}; iv = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (s_ov && out_rdy) res.push_back({s_bo, s_diff[7:0]});
      load = 1'b0;
      if (iv && s_ir) begin
        acc.push_back(c);
        idx++;
        load = 1'b1;
      end
      if (res.size() == 3) break;
      tick();
      if (load) begin
        if (idx < 3) begin
          a = {24'd0, pa[idx]}; b = {24'd0, pb[idx]};
        end else begin
          iv = 1'b0;
        end
      end
    end
    iv = 1'b0;
    tick(); tick();
    checks++;
    if (res.size() !== 3 || acc.size() !== 3) begin
      errors++; $display("FAIL b2b_count got results=%0d accepts=%0d want 3/3",
                         res.size(), acc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (res[i] !== exp_res[i]) begin
          errors++; $display("FAIL b2b_result%0d got %h want %h", i, res[i], exp_res[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] !== 10) begin
          errors++; $display("FAIL b2b_spacing%0d got %0d want 10", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_random(input bit w32, input int nops);
    logic [31:0] mask, ra, rb, exp_d, got_d;
    logic        exp_bo, got_bo;
    bit          bad;
    int          n, stall;
    sel32 = w32;
    mask  = w32 ? 32'hFFFF_FFFF : 32'h0000_00FF;
    iv = 1'b0; out_rdy = 1'b0;
    tick();
    for (int op = 0; op < nops; op++) begin
      bad = 1'b0;
      ra = $urandom & mask;
      rb = $urandom & mask;
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: begin ra = 32'h0; rb = mask; end
        default: ;
      endcase
      exp_d  = (ra - rb) & mask;
      exp_bo = (ra < rb);
      a = ra; b = rb; iv = 1'b1;
      out_rdy = 1'($urandom_range(0, 1));
      n = 0;
      while (!s_ir && n < 100) begin tick(); n++; end
      if (!s_ir) bad = 1'b1;
      tick();
      iv = 1'b0;
      n = 0;
      while (!s_ov && n < 100) begin
        if (s_ir && s_busy) bad = 1'b1;
        out_rdy = 1'($urandom_range(0, 1));
        tick(); n++;
      end
      if (!s_ov) bad = 1'b1;
      got_d  = s_diff;
      got_bo = s_bo;
      stall  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      out_rdy = (stall == 0);
      for (int k = 0; k < stall; k++) begin
        tick();
        if (!s_ov || s_diff !== got_d || s_bo !== got_bo || (s_ir && s_busy)) bad = 1'b1;
      end
      out_rdy = 1'b1;
      tick();
      if (s_ov || !s_ir || s_busy) bad = 1'b1;
      checks++;
      if ({got_bo, got_d} !== {exp_bo, exp_d}) begin
        errors++;
        $display("FAIL rand%0d_op%0d a=%h b=%h got %b/%h want %b/%h",
                 w32 ? 32 : 8, op, ra, rb, got_bo, got_d, exp_bo, exp_d);
      end
      checks++;
      if (bad !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_op%0d_protocol got violation=%b want 0",
                 w32 ? 32 : 8, op, bad);
      end
    end
    out_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
